multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle variant of the RV32I core. It sequences one shared ALU, the instruction/data memory port and the immediate extender over several cycles per instruction. From the fetched instruction fields it drives every datapath mux select, every write enable, the extender's imm_src and the ALU control. It sits beside the datapath, between the instruction register and all datapath control inputs.

---
 rtl/multicycle_controller.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core.
//
// It sequences the shared ALU, the unified instruction/data memory port and
// the immediate extender over several cycles per instruction. All datapath
// mux selects, write enables, imm_src and alu_control come from here.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   op           instr[6:0] from the instruction register
//   funct3       instr[14:12]
//   funct7b5     instr[30]
//   zero         ALU zero flag (combinational, current cycle)
//   mem_ready    memory access completes this cycle
//   pc_write     PC register enable
//   ir_write     instruction register / old_pc enable
//   adr_src      memory address select: 0 = PC, 1 = ALUOut
//   mem_write    data memory write strobe
//   reg_write    register file write enable
//   result_src   00 = ALUOut, 01 = memory data, 10 = ALU result direct
//   alu_src_a    00 = PC, 01 = old_pc, 10 = rs1
//   alu_src_b    00 = rs2, 01 = imm_ext, 10 = constant 4
//   alu_control  000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src      00 = I, 01 = S, 10 = B, 11 = J
//   illegal      high while parked in TRAP
//   state_o      current state encoding (debug)
//
// Parameter
//   ILLEGAL_TRAP 1 = unsupported opcode parks in TRAP until reset,
//                0 = unsupported opcode is skipped (DECODE -> FETCH)
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4 when memory is ready
// DECODE   | old_pc + imm into ALUOut (branch / jump target)
// MEMADR   | rs1 + imm into ALUOut (load/store address)
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | write loaded data to the register file
// MEMWRITE | write data memory at ALUOut, strobe held until mem_ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALUOut to the register file
// BRANCH   | rs1 - rs2, take branch target from ALUOut on condition
// JAL      | link value old_pc + 4, PC <= jump target from ALUOut
// TRAP     | unsupported opcode, parked until reset

module multicycle_controller #(
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  state_t     state;
  state_t     state_next;
  logic [2:0] alu_dec;
  logic       pc_write_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // funct7b5 only selects sub for register-register ops; for OP-IMM it is
  // part of the immediate and must not turn addi into a subtract.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next  = state;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    illegal     = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        if (mem_ready) begin
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
        endcase
      end

      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_STORE) begin
          imm_src    = IMM_S;
          state_next = S_MEMWRITE;
        end else begin
          imm_src    = IMM_I;
          state_next = S_MEMREAD;
        end
      end

      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        result_src  = RES_MEM;
        reg_write_s = 1'b1;
        state_next  = S_FETCH;
      end

      // The strobe stays up for the whole wait so the memory sees one
      // continuous write request.
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) begin
          state_next = S_FETCH;
        end
      end

      S_EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = alu_dec;
        state_next  = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        alu_control = alu_dec;
        state_next  = S_ALUWB;
      end

      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_s = 1'b1;
        state_next  = S_FETCH;
      end

      // ALUOut still holds the target computed in DECODE; result_src = 00
      // routes it to the PC while the ALU compares rs1 and rs2.
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        imm_src     = IMM_B;
        case (funct3)
          3'b000:  pc_write_s = zero;
          3'b001:  pc_write_s = ~zero;
          default: pc_write_s = 1'b0;
        endcase
        state_next = S_FETCH;
      end

      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write_s = 1'b1;
        imm_src    = IMM_J;
        state_next = S_ALUWB;
      end

      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // FETCH enables follow mem_ready combinationally, so reset must mask them
  // directly; the state register alone cannot keep them low.
  assign pc_write  = pc_write_s  & ~reset;
  assign ir_write  = ir_write_s  & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign state_o   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.ILLEGAL_TRAP(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, mw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } ctl_t;

  typedef struct {
    ctl_t e;
    logic mr;
    logic z;
  } step_t;

  ctl_t  obs;
  step_t q[$];

  assign obs = {state_o, pc_write, ir_write, adr_src, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};

  function automatic ctl_t at(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  // ALU operation an instruction asks for, from the ISA encoding.
  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input ctl_t e, input logic mr, input logic z);
    step_t s;
    s.e = e; s.mr = mr; s.z = z;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle control for one instruction, including memory
  // wait cycles.
  task automatic build_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mwait);
    ctl_t c;
    for (int i = 0; i < fw; i++) begin
      c = at(4'd0); c.sb = 2'd2; c.rs = 2'd2;
      push(c, 1'b0, rbit());
    end
    c = at(4'd0); c.sb = 2'd2; c.rs = 2'd2; c.pcw = 1'b1; c.irw = 1'b1;
    push(c, 1'b1, rbit());
    c = at(4'd1); c.sa = 2'd1; c.sb = 2'd1; c.imm = (o == OP_JAL) ? 2'd3 : 2'd2;
    push(c, rbit(), rbit());
    case (o)
      OP_LW, OP_SW: begin
        c = at(4'd2); c.sa = 2'd2; c.sb = 2'd1; c.imm = (o == OP_SW) ? 2'd1 : 2'd0;
        push(c, rbit(), rbit());
        if (o == OP_LW) begin
          for (int i = 0; i < mwait; i++) begin
            c = at(4'd3); c.adr = 1'b1;
            push(c, 1'b0, rbit());
          end
          c = at(4'd3); c.adr = 1'b1;
          push(c, 1'b1, rbit());
          c = at(4'd4); c.rs = 2'd1; c.rw = 1'b1;
          push(c, rbit(), rbit());
        end else begin
          for (int i = 0; i <= mwait; i++) begin
            c = at(4'd5); c.adr = 1'b1; c.mw = 1'b1;
            push(c, (i == mwait), rbit());
          end
        end
      end
      OP_R, OP_I: begin
        c = at((o == OP_R) ? 4'd6 : 4'd7); c.sa = 2'd2;
        c.sb = (o == OP_R) ? 2'd0 : 2'd1; c.alu = alu_ref(o, f3, f7);
        push(c, rbit(), rbit());
        c = at(4'd8); c.rw = 1'b1;
        push(c, rbit(), rbit());
      end
      OP_B: begin
        c = at(4'd9); c.sa = 2'd2; c.alu = 3'b001; c.imm = 2'd2;
        c.pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
        push(c, rbit(), z);
      end
      default: begin
        c = at(4'd10); c.sa = 2'd1; c.sb = 2'd2; c.pcw = 1'b1; c.imm = 2'd3;
        push(c, rbit(), rbit());
        c = at(4'd8); c.rw = 1'b1;
        push(c, rbit(), rbit());
      end
    endcase
  endtask

  task automatic drive(input logic mr, input logic z);
    @(negedge clk);
    mem_ready = mr;
    zero = z;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t c;
    mem_ready = 1'b1;
    #2;
    c = at(4'd0); c.sb = 2'd2; c.rs = 2'd2;
    checks++;
    if (obs !== c) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, c);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || ir_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d ir_write=%b expected 0/0", state_o, ir_write);
    end
  endtask

  task automatic test_fetch_wait();
    logic [3:0] exp_st[6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd7};
    logic       mr_seq[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int pulses = 0;
    set_instr(OP_I, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(mr_seq[i], 1'b0);
      if (ir_write === 1'b1) pulses++;
      checks++;
      if (state_o !== exp_st[i] || ir_write !== mr_seq[i] || pc_write !== mr_seq[i]) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: state=%0d ir=%b pc=%b expected %0d/%b/%b",
                 i, state_o, ir_write, pc_write, exp_st[i], mr_seq[i], mr_seq[i]);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL fetch_pulse_count: got %0d expected 1", pulses);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_lw();
    logic [3:0] exp_st[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    set_instr(OP_LW, 3'b010, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (state_o !== exp_st[i] || reg_write !== (exp_st[i] == 4'd4)) begin
        errors++;
        $display("FAIL lw_seq[%0d]: state=%0d reg_write=%b expected state %0d",
                 i, state_o, reg_write, exp_st[i]);
      end
      if (i == 2) begin
        checks++;
        if (imm_src !== 2'b00) begin
          errors++;
          $display("FAIL lw_memadr_imm: got %b expected 00", imm_src);
        end
      end
      if (i == 4) begin
        checks++;
        if (result_src !== 2'b01) begin
          errors++;
          $display("FAIL lw_memwb_result: got %b expected 01", result_src);
        end
      end
    end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  task automatic test_alu_decode();
    set_instr(OP_R, 3'b000, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (state_o !== 4'd6 || alu_control !== 3'b001) begin
      errors++;
      $display("FAIL sub_exec: state=%0d alu=%b expected 6/001", state_o, alu_control);
    end
    drive(1'b0, 1'b0);
    set_instr(OP_I, 3'b000, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (state_o !== 4'd7 || alu_control !== 3'b000) begin
      errors++;
      $display("FAIL addi_f7_exec: state=%0d alu=%b expected 7/000", state_o, alu_control);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_branch();
    set_instr(OP_B, 3'b000, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (imm_src !== 2'b10) begin
      errors++;
      $display("FAIL branch_decode_imm: got %b expected 10", imm_src);
    end
    drive(1'b0, 1'b1);
    checks++;
    if (state_o !== 4'd9 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken: state=%0d pc_write=%b expected 9/1", state_o, pc_write);
    end
    set_instr(OP_B, 3'b001, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    checks++;
    if (state_o !== 4'd9 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL bne_not_taken: state=%0d pc_write=%b expected 9/0", state_o, pc_write);
    end
  endtask

  task automatic test_jal_trap();
    set_instr(OP_JAL, 3'b000, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (imm_src !== 2'b11) begin
      errors++;
      $display("FAIL jal_decode_imm: got %b expected 11", imm_src);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (state_o !== 4'd10 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL jal_state: state=%0d pc_write=%b expected 10/1", state_o, pc_write);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (state_o !== 4'd8 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL jal_aluwb: state=%0d reg_write=%b expected 8/1", state_o, reg_write);
    end
    set_instr(OP_BAD, 3'b000, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (state_o !== 4'd11 || illegal !== 1'b1 ||
          {pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin
        errors++;
        $display("FAIL trap_hold[%0d]: state=%0d illegal=%b enables=%b expected 11/1/0000",
                 i, state_o, illegal, {pc_write, ir_write, mem_write, reg_write});
      end
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_write();
    set_instr(OP_SW, 3'b010, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (state_o !== 4'd5 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL sw_wait: state=%0d mem_write=%b expected 5/1", state_o, mem_write);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_write: mem_write=%b state=%0d expected 0/0", mem_write, state_o);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write_release: state=%0d mem_write=%b expected 0/0",
               state_o, mem_write);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL};
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7, z;
    for (int n = 0; n < 60; n++) begin
      o  = ops[$urandom_range(0, 5)];
      f3 = (o == OP_LW || o == OP_SW) ? 3'b010 : 3'($urandom_range(0, 7));
      f7 = rbit();
      z  = rbit();
      q.delete();
      build_instr(o, f3, f7, z, $urandom_range(0, 2), $urandom_range(0, 2));
      set_instr(o, f3, f7);
      for (int k = 0; k < q.size(); k++) begin
        drive(q[k].mr, q[k].z);
        checks++;
        if (obs !== q[k].e) begin
          errors++;
          $display("FAIL random[%0d] op=%b f3=%b step %0d: got %h expected %h",
                   n, o, f3, k, obs, q[k].e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_lw();
    test_alu_decode();
    test_branch();
    test_jal_trap();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
